iir_decim_fifo: RTL and testbench
=================================

Name: iir_decim_fifo

Overview:
- Downstream stage of the 4-bit signed IIR filter.
- Takes one filter output sample per cycle when in_valid is high and averages each block of 2^DECIM_LOG2 samples into one decimated sample.
- Buffers the averaged samples in a small FIFO and presents them to the next consumer over a valid/ready handshake.
- Reports dropped results through a sticky overflow flag. The IIR filter has no backpressure, so this block never stalls its input.

Parameters:
- DATA_W, 4, sample width, two's complement; matches the IIR output.
- DECIM_LOG2, 2, log2 of the decimation factor N; N = 4 by default. Legal range 1..4.
- FIFO_AW, 2, FIFO address width; depth = 2^FIFO_AW = 4 entries.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  in_data is a valid IIR sample this cycle
- in_data  in  DATA_W  signed IIR output sample
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts out_data this cycle
- out_data  out  DATA_W  signed decimated sample at FIFO head
- fifo_level  out  FIFO_AW+1  number of occupied entries, 0..2^FIFO_AW
- overflow  out  1  sticky: a result was dropped because the FIFO was full
- clr_ovf  in  1  clears overflow

Behaviour:
- Reset (rst=1 at a clk edge):
  - acc=0, cnt=0, wr_ptr=0, rd_ptr=0, fifo_level=0, overflow=0.
  - Outputs: out_valid=0, out_data=0.
  - FIFO storage is not reset.
  - Reset mid-block discards the partial sum; the next block starts fresh.
- Accumulator:
  - ACC_W = DATA_W + DECIM_LOG2, signed. in_data is sign-extended to ACC_W.
  - cnt counts 0..N-1 and advances only on in_valid=1. Cycles with in_valid=0 change nothing.
  - in_valid=1 and cnt<N-1: acc <= acc + sext(in_data); cnt <= cnt+1.
  - in_valid=1 and cnt==N-1:
    - sum = acc + sext(in_data);
    - result = sum >>> DECIM_LOG2 (arithmetic shift, floor), truncated to DATA_W;
    - push result; acc <= 0; cnt <= 0.
  - result always fits in DATA_W: the average of in-range values stays in range. No saturation logic is required.
- Push timing:
  - The push is written at the same clk edge that consumes the N-th sample.
  - out_valid rises on the cycle after that edge, i.e. 1-cycle latency from the last sample.
- FIFO:
  - out_data = mem[rd_ptr] when fifo_level!=0, else 0. The output is combinational from registers.
  - out_valid = (fifo_level != 0).
  - Pop occurs when out_valid && out_ready: rd_ptr++, level--.
  - out_ready while empty is ignored.
  - Pointers wrap modulo 2^FIFO_AW.
- Simultaneous events:
  - push and pop in the same cycle: both happen; level unchanged. This also applies when full, because the pop frees the slot.
  - push while full with no pop: result dropped, pointers and level unchanged, overflow <= 1.
  - clr_ovf=1 clears overflow at the next edge. If a drop occurs in the same cycle, set wins and overflow stays 1.
- Output registers: fifo_level and overflow are registered. No combinational path from in_* to out_*.

Optional Feature:
- Macro: IIR_DECIM_ROUND_EN.
- Defined: result = (sum + 2^(DECIM_LOG2-1)) >>> DECIM_LOG2, i.e. round-half-up. The biased sum must not overflow ACC_W; it cannot, since |sum| <= 2^(DATA_W-1)*N and the bias < N.
- Undefined: truncation (floor) as above. Bias logic is absent.
- All other behaviour is identical in both builds.

Test Plan:
1. Basic block and latency:
   - Stimulus: reset; in_valid=1 with samples 1,2,3,4; out_ready=0.
   - Response: out_valid=1 one cycle after the 4th sample edge; out_data=2 (sum 10, floored); fifo_level=1.
   - With IIR_DECIM_ROUND_EN: out_data=3.
2. Negative values:
   - Stimulus: samples -1,-2,-3,-3.
   - Response: out_data=-3 (4'b1101, floor of -2.25); with IIR_DECIM_ROUND_EN: -2 (4'b1110).
   - Stimulus: samples -8,-8,-8,-8.
   - Response: out_data=-8 in both builds.
3. Gaps in in_valid:
   - Stimulus: samples 4, (valid=0 for 3 cycles), 4, 4, (valid=0), 4.
   - Response: exactly one result, value 4. Idle cycles do not advance cnt.
4. Overflow:
   - Stimulus: out_ready=0; 16 samples of 7.
   - Response: fifo_level=4, overflow=0.
   - Stimulus: 4 more samples of 7.
   - Response: result dropped; overflow=1; fifo_level stays 4.
   - Stimulus: drain with out_ready=1.
   - Response: 7,7,7,7 in order, then out_valid=0.
   - Stimulus: pulse clr_ovf.
   - Response: overflow=0.
5. Push+pop when full:
   - Stimulus: FIFO full with values 1,2,3,4; out_ready=1 on the cycle a new result 5 is pushed.
   - Response: 1 popped; level stays 4; overflow=0; subsequent order is 2,3,4,5.
6. Reset mid-operation:
   - Stimulus: samples 5,5; rst for 1 cycle; then samples 1,1,1,1.
   - Response: single output 1; fifo_level=0 and out_valid=0 immediately after reset.

Source files
------------

// File: rtl/iir_decim_fifo.sv
// iir_decim_fifo
//   Downstream stage of the 4-bit signed IIR filter. It averages each block of
//   2^DECIM_LOG2 valid input samples into one decimated sample. Results go into
//   a small FIFO that is read over a valid/ready handshake. The input is never
//   stalled. A result that arrives while the FIFO is full and nothing is being
//   popped is dropped, and the sticky overflow flag is set.
//
//   Build option: define IIR_DECIM_ROUND_EN to round the average half-up.
//   The default build truncates (floor).
//
// Ports:
//   clk         clock
//   rst         synchronous, active-high reset
//   in_valid    in_data carries a valid IIR sample this cycle
//   in_data     signed IIR sample, DATA_W bits
//   out_valid   FIFO non-empty
//   out_ready   consumer accepts out_data this cycle
//   out_data    signed decimated sample at the FIFO head (0 when empty)
//   fifo_level  occupied entries, 0..2^FIFO_AW
//   overflow    sticky: a result was dropped because the FIFO was full
//   clr_ovf     clears overflow (a same-cycle drop takes priority)
module iir_decim_fifo #(
    parameter int DATA_W     = 4,
    parameter int DECIM_LOG2 = 2,
    parameter int FIFO_AW    = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic [FIFO_AW:0]         fifo_level,
    output logic                     overflow,
    input  logic                     clr_ovf
);
    localparam int ACC_W = DATA_W + DECIM_LOG2;
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [DECIM_LOG2-1:0] CNT_LAST = '1;
    localparam logic [FIFO_AW:0]      LVL_FULL = (FIFO_AW + 1)'(DEPTH);
`ifdef IIR_DECIM_ROUND_EN
    localparam logic signed [ACC_W-1:0] RND_BIAS = ACC_W'(1 << (DECIM_LOG2 - 1));
`endif

    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [DECIM_LOG2-1:0]    cnt_q, cnt_d;
    logic [FIFO_AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]         level_q, level_d;
    logic                     ovf_q, ovf_d;
    logic signed [DATA_W-1:0] mem_q [DEPTH];

    logic signed [ACC_W-1:0]  sum;
    logic signed [DATA_W-1:0] result;
    logic push, pop, full, wr_en, drop;

    // Block sum divided by N with an arithmetic shift. The average of in-range
    // samples is itself in range, so dropping the upper bits is lossless.
    function automatic logic signed [DATA_W-1:0] avg_scale(input logic signed [ACC_W-1:0] s);
        logic signed [ACC_W-1:0] shifted;
`ifdef IIR_DECIM_ROUND_EN
        // |s| <= 2^(DATA_W-1)*N and the bias is below N, so s + bias fits in ACC_W.
        shifted = (s + RND_BIAS) >>> DECIM_LOG2;
`else
        shifted = s >>> DECIM_LOG2;
`endif
        return DATA_W'(shifted);
    endfunction

    always_comb begin
        sum    = acc_q + $signed({{DECIM_LOG2{in_data[DATA_W-1]}}, in_data});
        result = avg_scale(sum);
        push   = in_valid && (cnt_q == CNT_LAST);
        pop    = out_valid && out_ready;
        full   = (level_q == LVL_FULL);
        // A pop in the same cycle frees a slot, so a push into a full FIFO still succeeds.
        wr_en  = push && (!full || pop);
        drop   = push && full && !pop;

        acc_d = acc_q;
        cnt_d = cnt_q;
        if (in_valid) begin
            if (push) begin
                acc_d = '0;
                cnt_d = '0;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + 1'b1;
            end
        end

        wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop   ? rd_ptr_q + 1'b1 : rd_ptr_q;

        level_d = level_q;
        case ({wr_en, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        // A drop in the same cycle as clr_ovf keeps the flag set.
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    // Control and accumulator state
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
        end
    end

    // FIFO storage is data only and carries no reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= result;
        end
    end

    assign out_valid  = (level_q != '0);
    assign out_data   = out_valid ? mem_q[rd_ptr_q] : '0;
    assign fifo_level = level_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_iir_decim_fifo.sv
module tb_iir_decim_fifo;
    localparam int DATA_W     = 4;
    localparam int DECIM_LOG2 = 2;
    localparam int FIFO_AW    = 2;
    localparam int N          = 1 << DECIM_LOG2;
    localparam int DEPTH      = 1 << FIFO_AW;
`ifdef IIR_DECIM_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, in_valid, out_valid, out_ready, overflow, clr_ovf;
    logic signed [DATA_W-1:0] in_data, out_data;
    logic [FIFO_AW:0] fifo_level;

    int checks = 0;
    int errors = 0;

    // Reference model: block sum/count and a queue standing in for the FIFO.
    int m_q[$];
    int m_sum = 0;
    int m_cnt = 0;
    bit m_ovf = 1'b0;

    typedef struct {
        bit rst; bit v; int d; bit rdy; bit clr;
        int ev; int ed; int el; int eo;
    } vec_t;
    vec_t vecs[$];

    always #5 clk = ~clk;

    iir_decim_fifo #(.DATA_W(DATA_W), .DECIM_LOG2(DECIM_LOG2), .FIFO_AW(FIFO_AW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .fifo_level(fifo_level), .overflow(overflow), .clr_ovf(clr_ovf)
    );

    function automatic int floor_div(int s, int n);
        int q = s / n;
        if ((s % n != 0) && (s < 0)) q--;
        return q;
    endfunction

    function automatic int block_avg(int s);
        return RND ? floor_div(s + N / 2, N) : floor_div(s, N);
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance the model across one edge, using the inputs currently driven.
    task automatic model_edge();
        bit pop;
        bit push;
        int res;
        pop  = (m_q.size() != 0) && out_ready;
        push = 1'b0;
        res  = 0;
        if (rst) begin
            m_q.delete();
            m_sum = 0;
            m_cnt = 0;
            m_ovf = 1'b0;
        end else begin
            if (in_valid) begin
                m_sum += int'(in_data);
                if (m_cnt == N - 1) begin
                    push  = 1'b1;
                    res   = block_avg(m_sum);
                    m_sum = 0;
                    m_cnt = 0;
                end else begin
                    m_cnt++;
                end
            end
            if (pop) void'(m_q.pop_front());
            if (push) begin
                if (m_q.size() < DEPTH) m_q.push_back(res);
                else m_ovf = 1'b1;
            end
            if (!(push && m_q.size() == DEPTH && !pop && res == res && m_ovf) && clr_ovf && !(push && !pop && m_ovf && m_q.size() == DEPTH))
                m_ovf = 1'b0;
        end
    endtask

    task automatic model_cmp();
        check("mdl_valid", int'(out_valid), (m_q.size() != 0) ? 1 : 0);
        check("mdl_data",  int'(out_data),  (m_q.size() != 0) ? m_q[0] : 0);
        check("mdl_level", int'(fifo_level), m_q.size());
        check("mdl_ovf",   int'(overflow),  int'(m_ovf));
    endtask

    task automatic step(bit r, bit v, int d, bit rdy, bit clr);
        rst       = r;
        in_valid  = v;
        in_data   = d[DATA_W-1:0];
        out_ready = rdy;
        clr_ovf   = clr;
        model_edge();
        @(posedge clk);
        #1;
        model_cmp();
    endtask

    task automatic idle(); step(1'b0, 1'b0, 0, 1'b0, 1'b0); endtask
    task automatic smp(int d); step(1'b0, 1'b1, d, 1'b0, 1'b0); endtask

    function automatic void add(bit r, bit v, int d, bit rdy, bit clr, int ev, int ed, int el, int eo);
        vec_t x;
        x.rst = r; x.v = v; x.d = d; x.rdy = rdy; x.clr = clr;
        x.ev = ev; x.ed = ed; x.el = el; x.eo = eo;
        vecs.push_back(x);
    endfunction

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; clr_ovf = 1'b0;
        @(posedge clk);
        #1;

        // Expected outputs are those visible just after the row's clock edge.
        add(1, 0, 0, 0, 0, 0, 0, 0, 0);                      // reset state
        add(0, 1, 1, 0, 0, 0, 0, 0, 0);
        add(0, 1, 2, 0, 0, 0, 0, 0, 0);
        add(0, 1, 3, 0, 0, 0, 0, 0, 0);
        add(0, 1, 4, 0, 0, 1, RND ? 3 : 2, 1, 0);            // sum 10
        add(0, 0, 0, 1, 0, 0, 0, 0, 0);                      // pop
        add(0, 1, -1, 0, 0, 0, 0, 0, 0);
        add(0, 1, -2, 0, 0, 0, 0, 0, 0);
        add(0, 1, -3, 0, 0, 0, 0, 0, 0);
        add(0, 1, -3, 0, 0, 1, RND ? -2 : -3, 1, 0);         // sum -9
        add(0, 0, 0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 1, -8, 0, 0, 0, 0, 0, 0);
        add(0, 1, -8, 0, 0, 1, -8, 1, 0);
        add(0, 0, 0, 1, 0, 0, 0, 0, 0);
        add(0, 1, 4, 0, 0, 0, 0, 0, 0);                      // gaps in in_valid
        for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 4, 0, 0, 0, 0, 0, 0);
        add(0, 1, 4, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 4, 0, 0, 1, 4, 1, 0);
        add(0, 0, 0, 0, 0, 1, 4, 1, 0);                      // held, no second result
        add(0, 0, 0, 1, 0, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].v, vecs[i].d, vecs[i].rdy, vecs[i].clr);
            check($sformatf("vec%0d_valid", i), int'(out_valid),  vecs[i].ev);
            check($sformatf("vec%0d_data", i),  int'(out_data),   vecs[i].ed);
            check($sformatf("vec%0d_level", i), int'(fifo_level), vecs[i].el);
            check($sformatf("vec%0d_ovf", i),   int'(overflow),   vecs[i].eo);
        end

        // Overflow: fill, drop one, drain, clear.
        for (int i = 0; i < 16; i++) smp(7);
        check("full_level", int'(fifo_level), 4);
        check("full_ovf",   int'(overflow),   0);
        for (int i = 0; i < 4; i++) smp(7);
        check("drop_level", int'(fifo_level), 4);
        check("drop_ovf",   int'(overflow),   1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain%0d_data", i), int'(out_data), 7);
            step(1'b0, 1'b0, 0, 1'b1, 1'b0);
        end
        check("drained_valid", int'(out_valid), 0);
        check("ovf_sticky",    int'(overflow),  1);
        step(1'b0, 1'b0, 0, 1'b0, 1'b1);
        check("ovf_cleared",   int'(overflow),  0);

        // Push and pop on the same edge while full.
        for (int k = 1; k <= 4; k++) for (int i = 0; i < 4; i++) smp(k);
        check("pp_level0", int'(fifo_level), 4);
        for (int i = 0; i < 3; i++) smp(5);
        step(1'b0, 1'b1, 5, 1'b1, 1'b0);
        check("pp_level", int'(fifo_level), 4);
        check("pp_ovf",   int'(overflow),   0);
        for (int k = 2; k <= 5; k++) begin
            check($sformatf("pp_order%0d", k), int'(out_data), k);
            step(1'b0, 1'b0, 0, 1'b1, 1'b0);
        end
        check("pp_empty", int'(out_valid), 0);

        // Reset in the middle of a block.
        smp(5); smp(5);
        step(1'b1, 1'b0, 0, 1'b0, 1'b0);
        check("rst_level", int'(fifo_level), 0);
        check("rst_valid", int'(out_valid),  0);
        for (int i = 0; i < 4; i++) smp(1);
        check("rst_data",  int'(out_data),   1);
        check("rst_lvl1",  int'(fifo_level), 1);
        step(1'b0, 1'b0, 0, 1'b1, 1'b0);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 3) != 0),
                 int'($urandom_range(0, 15)) - 8,
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 15) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
